// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - EX-side flag/branch bus and redirect/flush outputs of branch_resolve.
// Optional rs1_msb/rs2_msb signals exist only when BR_OVF_FIX_EN is defined.
interface branch_resolve_if;
    logic        ex_valid;
    logic [2:0]  ex_br_type;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] alu_c;
    logic        alu_zero;
    logic        alu_sgn;
    logic        stall;
`ifdef BR_OVF_FIX_EN
    logic        rs1_msb;
    logic        rs2_msb;
`endif
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic        busy;

`ifdef BR_OVF_FIX_EN
    modport master (
        output ex_valid, ex_br_type, ex_pc, ex_imm, alu_c, alu_zero, alu_sgn, stall,
               rs1_msb, rs2_msb,
        input  redirect_valid, redirect_pc, flush_if, flush_id, busy
    );
    modport slave (
        input  ex_valid, ex_br_type, ex_pc, ex_imm, alu_c, alu_zero, alu_sgn, stall,
               rs1_msb, rs2_msb,
        output redirect_valid, redirect_pc, flush_if, flush_id, busy
    );
`else
    modport master (
        output ex_valid, ex_br_type, ex_pc, ex_imm, alu_c, alu_zero, alu_sgn, stall,
        input  redirect_valid, redirect_pc, flush_if, flush_id, busy
    );
    modport slave (
        input  ex_valid, ex_br_type, ex_pc, ex_imm, alu_c, alu_zero, alu_sgn, stall,
        output redirect_valid, redirect_pc, flush_if, flush_id, busy
    );
`endif
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch/jump resolution with registered redirect and IF/ID flush window.
// Optional BR_OVF_FIX_EN: use operand MSBs to correct signed compare under subtraction overflow.
module branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolve_if.slave  bus
);
    typedef enum logic { IDLE, FLUSH } state_e;

    localparam logic [1:0] FLUSH_LOAD = FLUSH_CYCLES[1:0];

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic        rv_q;
    logic [31:0] pc_q;
    logic        flush_q;

    logic        lt;
    logic        taken;
    logic [31:0] target;

`ifdef BR_OVF_FIX_EN
    // Differing operand signs decide the compare outright; the SUB sign is only trusted otherwise.
    assign lt = (bus.rs1_msb != bus.rs2_msb) ? bus.rs1_msb : bus.alu_sgn;
`else
    assign lt = bus.alu_sgn;
`endif

    always_comb begin
        taken  = 1'b0;
        target = bus.ex_pc + bus.ex_imm;
        case (bus.ex_br_type)
            3'b001:  taken = bus.alu_zero;
            3'b010:  taken = !bus.alu_zero;
            3'b011:  taken = lt;
            3'b100:  taken = !lt;
            3'b101:  taken = 1'b1;
            3'b110: begin
                taken  = 1'b1;
                target = {bus.alu_c[31:1], 1'b0};
            end
            default: taken = 1'b0;
        endcase
    end

    // A stall freezes everything, including a pending redirect pulse, so the PC sees it exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            rv_q    <= 1'b0;
            pc_q    <= 32'd0;
            flush_q <= 1'b0;
        end else if (!bus.stall) begin
            case (state_q)
                IDLE: begin
                    if (bus.ex_valid && taken) begin
                        state_q <= FLUSH;
                        cnt_q   <= FLUSH_LOAD;
                        rv_q    <= 1'b1;
                        pc_q    <= target;
                        flush_q <= 1'b1;
                    end else begin
                        rv_q    <= 1'b0;
                    end
                end
                FLUSH: begin
                    rv_q  <= 1'b0;
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.flush_if       = flush_q;
    assign bus.flush_id       = flush_q;
    assign bus.busy           = flush_q;
endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve (directed scenarios plus random vs reference model).
module tb_branch_resolve;
  localparam int FC = 2;

  logic        clk;
  logic        rst;
  int          n_checks;
  int          n_fail;
  logic [31:0] model_pc;

  branch_resolve_if bus();

  branch_resolve #(.FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [3:0] status();
    return {bus.redirect_valid, bus.flush_if, bus.flush_id, bus.busy};
  endfunction

  // Reference decision from architectural operands rather than ALU flags.
  function automatic logic [32:0] ref_resolve(input logic [2:0] t, input logic [31:0] pc,
                                              input logic [31:0] imm, input logic [31:0] rs1,
                                              input logic [31:0] rs2);
    logic        lt;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] diff;
    diff = rs1 - rs2;
`ifdef BR_OVF_FIX_EN
    lt = $signed(rs1) < $signed(rs2);
`else
    lt = diff[31];
`endif
    tgt = pc + imm;
    case (t)
      3'd1: tk = (rs1 == rs2);
      3'd2: tk = (rs1 != rs2);
      3'd3: tk = lt;
      3'd4: tk = !lt;
      3'd5: tk = 1'b1;
      3'd6: begin tk = 1'b1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
      default: tk = 1'b0;
    endcase
    return {tk, tgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.ex_valid = 1'b0; bus.ex_br_type = 3'd0; bus.ex_pc = 32'd0; bus.ex_imm = 32'd0;
    bus.alu_c = 32'd0; bus.alu_zero = 1'b0; bus.alu_sgn = 1'b0; bus.stall = 1'b0;
`ifdef BR_OVF_FIX_EN
    bus.rs1_msb = 1'b0; bus.rs2_msb = 1'b0;
`endif
  endtask

  task automatic present(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2);
    logic [31:0] c;
    c = (t == 3'd6) ? rs1 + imm : rs1 - rs2;
    bus.ex_valid = 1'b1; bus.ex_br_type = t; bus.ex_pc = pc; bus.ex_imm = imm;
    bus.alu_c = c; bus.alu_zero = (c == 32'd0); bus.alu_sgn = c[31];
`ifdef BR_OVF_FIX_EN
    bus.rs1_msb = rs1[31]; bus.rs2_msb = rs2[31];
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    n_checks++; if (status() !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b want %b", status(), 4'b0000); end
    n_checks++; if (bus.redirect_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.redirect_pc, 32'd0); end
    rst = 1'b0;
    model_pc = 32'd0;
    tick();
    n_checks++; if (status() !== 4'b0000) begin n_fail++; $display("FAIL reset_idle: got %b want %b", status(), 4'b0000); end
  endtask

  task automatic test_beq_taken();
    present(3'd1, 32'h100, 32'h20, 32'd5, 32'd5);
    tick();
    model_pc = 32'h120;
    n_checks++; if (status() !== 4'b1111) begin n_fail++; $display("FAIL beq_first: got %b want %b", status(), 4'b1111); end
    n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL beq_pc: got %h want %h", bus.redirect_pc, model_pc); end
    bus.ex_valid = 1'b0;
    tick();
    n_checks++; if (status() !== 4'b0111) begin n_fail++; $display("FAIL beq_second: got %b want %b", status(), 4'b0111); end
    tick();
    n_checks++; if (status() !== 4'b0000) begin n_fail++; $display("FAIL beq_done: got %b want %b", status(), 4'b0000); end
  endtask

  task automatic test_bne_not_taken();
    present(3'd2, 32'h200, 32'h40, 32'd7, 32'd7);
    tick();
    n_checks++; if (status() !== 4'b0000) begin n_fail++; $display("FAIL bne_status: got %b want %b", status(), 4'b0000); end
    n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL bne_pc_hold: got %h want %h", bus.redirect_pc, model_pc); end
    bus.ex_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    present(3'd6, 32'h300, 32'd5, 32'h2000, 32'd0);
    tick();
    model_pc = 32'h2004;
    n_checks++; if (status() !== 4'b1111) begin n_fail++; $display("FAIL jalr_first: got %b want %b", status(), 4'b1111); end
    n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL jalr_pc: got %h want %h", bus.redirect_pc, model_pc); end
    present(3'd1, 32'h500, 32'h10, 32'd1, 32'd1);
    tick();
    n_checks++; if (status() !== 4'b0111) begin n_fail++; $display("FAIL b2b_flush: got %b want %b", status(), 4'b0111); end
    tick();
    n_checks++; if (status() !== 4'b0000) begin n_fail++; $display("FAIL b2b_ignored: got %b want %b", status(), 4'b0000); end
    n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL b2b_pc_hold: got %h want %h", bus.redirect_pc, model_pc); end
    tick();
    model_pc = 32'h510;
    n_checks++; if (status() !== 4'b1111) begin n_fail++; $display("FAIL b2b_taken: got %b want %b", status(), 4'b1111); end
    n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL b2b_pc: got %h want %h", bus.redirect_pc, model_pc); end
    bus.ex_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stall();
    logic       seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp [5] = '{4'b1111, 4'b0111, 4'b0111, 4'b0111, 4'b0000};
    int         rv_seen;
    int         flush_n;
    present(3'd5, 32'h1000, 32'h100, 32'd0, 32'd0);
    bus.stall = 1'b1;
    tick();
    n_checks++; if (status() !== 4'b0000) begin n_fail++; $display("FAIL stall_idle: got %b want %b", status(), 4'b0000); end
    bus.stall = 1'b0;
    tick();
    model_pc = 32'h1100;
    n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL stall_pc: got %h want %h", bus.redirect_pc, model_pc); end
    bus.ex_valid = 1'b0;
    rv_seen = 0;
    flush_n = bus.flush_if ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      bus.stall = seq[i];
      if (bus.redirect_valid && !bus.stall) rv_seen++;
      tick();
      if (bus.flush_if) flush_n++;
      n_checks++; if (status() !== exp[i]) begin n_fail++; $display("FAIL stall_step%0d: got %b want %b", i, status(), exp[i]); end
    end
    n_checks++; if (rv_seen !== 1) begin n_fail++; $display("FAIL stall_rv_once: got %0d want %0d", rv_seen, 1); end
    n_checks++; if (flush_n !== FC + 3) begin n_fail++; $display("FAIL stall_flush_len: got %0d want %0d", flush_n, FC + 3); end
    n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL stall_pc_hold: got %h want %h", bus.redirect_pc, model_pc); end
  endtask

  task automatic test_blt_overflow();
    present(3'd3, 32'h40, 32'h80, 32'h8000_0000, 32'd1);
    tick();
`ifdef BR_OVF_FIX_EN
    model_pc = 32'hC0;
    n_checks++; if (status() !== 4'b1111) begin n_fail++; $display("FAIL blt_ovf: got %b want %b", status(), 4'b1111); end
`else
    n_checks++; if (status() !== 4'b0000) begin n_fail++; $display("FAIL blt_ovf: got %b want %b", status(), 4'b0000); end
`endif
    n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL blt_pc: got %h want %h", bus.redirect_pc, model_pc); end
    bus.ex_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_flush();
    present(3'd5, 32'h700, 32'd4, 32'd0, 32'd0);
    tick();
    n_checks++; if (status() !== 4'b1111) begin n_fail++; $display("FAIL rstmid_pre: got %b want %b", status(), 4'b1111); end
    bus.ex_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_pc = 32'd0;
    n_checks++; if (status() !== 4'b0000) begin n_fail++; $display("FAIL rstmid_async: got %b want %b", status(), 4'b0000); end
    n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL rstmid_pc: got %h want %h", bus.redirect_pc, model_pc); end
    tick();
    rst = 1'b0;
    present(3'd5, 32'h40, 32'hFFFF_FFF8, 32'd0, 32'd0);
    tick();
    model_pc = 32'h38;
    n_checks++; if (status() !== 4'b1111) begin n_fail++; $display("FAIL rstmid_jal: got %b want %b", status(), 4'b1111); end
    n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL rstmid_jal_pc: got %h want %h", bus.redirect_pc, model_pc); end
    bus.ex_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [2:0]  t;
    logic [31:0] rs1, rs2, pc, imm;
    logic        st;
    logic [32:0] r;
    for (int it = 0; it < 80; it++) begin
      t   = 3'($urandom_range(0, 7));
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 2) == 0) ? rs1 : $urandom;
      pc  = $urandom;
      imm = $urandom;
      st  = ($urandom_range(0, 4) == 0);
      r   = ref_resolve(t, pc, imm, rs1, rs2);
      present(t, pc, imm, rs1, rs2);
      bus.ex_valid = ($urandom_range(0, 5) != 0);
      bus.stall = st;
      tick();
      bus.stall = 1'b0;
      if (r[32] && bus.ex_valid && !st) begin
        model_pc = r[31:0];
        n_checks++; if (status() !== 4'b1111) begin n_fail++; $display("FAIL rnd%0d_first: got %b want %b", it, status(), 4'b1111); end
        n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL rnd%0d_pc: got %h want %h", it, bus.redirect_pc, model_pc); end
        for (int k = 1; k < FC; k++) begin
          present(3'($urandom_range(1, 6)), $urandom, $urandom, $urandom, $urandom);
          tick();
          n_checks++; if (status() !== 4'b0111) begin n_fail++; $display("FAIL rnd%0d_flush: got %b want %b", it, status(), 4'b0111); end
        end
        tick();
        n_checks++; if (status() !== 4'b0000) begin n_fail++; $display("FAIL rnd%0d_end: got %b want %b", it, status(), 4'b0000); end
      end else begin
        n_checks++; if (status() !== 4'b0000) begin n_fail++; $display("FAIL rnd%0d_nt: got %b want %b", it, status(), 4'b0000); end
      end
      n_checks++; if (bus.redirect_pc !== model_pc) begin n_fail++; $display("FAIL rnd%0d_pc_hold: got %h want %h", it, bus.redirect_pc, model_pc); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_pc = 32'd0;
    rst      = 1'b1;
    set_idle();
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_back_to_back();
    test_stall();
    test_blt_overflow();
    test_reset_mid_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch/jump resolution unit for the pipelined CPU. Consumes the EX-stage ALU result and flags (`zero`, `sgn`, result word) plus the decoded branch type, and decides taken/not-taken. On a taken branch or jump it registers the redirect target toward the PC, then holds a flush window that kills wrong-path instructions in IF/ID. It sits on the consumer side of the ALU flag interface, between EX and the fetch/PC logic.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `flush_if`/`flush_id` stay high after a redirect; legal range 1..3.

Ports:
- `clk` in 1: clock. Rising edge active.
- `rst` in 1: reset. Asynchronous, active-high.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_br_type` in 3: branch type.
  - 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 JAL, 110 JALR.
  - 111 reserved; treated as none.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_imm` in 32: sign-extended branch/jump offset.
- `alu_c` in 32: ALU result. For branches this is rs1−rs2 (SUB); for JALR it is rs1+imm (ADD).
- `alu_zero` in 1: ALU zero flag.
- `alu_sgn` in 1: ALU result bit 31.
- `stall` in 1: pipeline freeze. Inputs are not sampled, and internal state holds.
- `redirect_valid` out 1: one-cycle pulse; the PC must load `redirect_pc`.
- `redirect_pc` out 32: registered redirect target.
- `flush_if` out 1: kill the IF/ID register contents.
- `flush_id` out 1: kill the ID/EX register contents.
- `busy` out 1: high while in the FLUSH state.

## Operation
Taken decision, combinational on the inputs:
- BEQ: `alu_zero`.
- BNE: `!alu_zero`.
- BLT: `lt`.
- BGE: `!lt`.
- JAL and JALR: always taken.
- `lt` = `alu_sgn` (see Configuration).

Target computation:
- Branches and JAL: `ex_pc + ex_imm`, modulo 2^32.
- JALR: `alu_c & 32'hFFFF_FFFE`.

State machine, IDLE/FLUSH, plus a 2-bit flush counter:
- **IDLE:** on a rising edge with `ex_valid=1`, `stall=0` and taken=1:
  - `redirect_valid` is set to 1 and `redirect_pc` is loaded with the target.
  - The counter is loaded with `FLUSH_CYCLES`, and the state goes to FLUSH.
  - If not taken, or the type is none/reserved: stay in IDLE, `redirect_valid` is 0, and `redirect_pc` holds its old value.
- **FLUSH:**
  - `flush_if = flush_id = busy = 1`.
  - `redirect_valid` is 1 only in the first FLUSH cycle.
  - Each non-stalled edge decrements the counter. When the counter reaches 1 and `stall=0`, the next state is IDLE.
  - `ex_valid` is ignored in FLUSH, because those instructions are wrong-path.
- **Stall:**
  - `stall=1` freezes the state, counter and `redirect_pc`.
  - `redirect_valid`, if high, stays high until the first non-stalled edge, so the PC sees it exactly once.
- **Reset:**
  - Applies asynchronously at any time, including mid-FLUSH.
  - State IDLE, counter 0, and `redirect_valid`, `redirect_pc`, `flush_if`, `flush_id`, `busy` all 0.

## Timing
- Decision latency is 1 cycle. A taken instruction sampled at edge N gives `redirect_valid=1` and a valid `redirect_pc` during cycle N..N+1.
- Flush is high for `FLUSH_CYCLES` non-stalled cycles starting at cycle N.
- Back-to-back: an instruction in EX at the edge that returns the unit to IDLE is still ignored. The first decision is taken at the following edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
Macro `BR_OVF_FIX_EN`:
- **Defined:** adds inputs `rs1_msb` and `rs2_msb` (1 bit each), and `lt = (rs1_msb != rs2_msb) ? rs1_msb : alu_sgn`. This gives a correct signed compare under subtraction overflow.
- **Undefined:** those ports are absent and `lt = alu_sgn`. A signed compare that overflows on subtraction then resolves wrongly, which is accepted for the reduced test programs.

## Test plan
- **BEQ taken.** `ex_pc=0x100`, `ex_imm=0x20`, `alu_zero=1`, type 001 → next cycle `redirect_valid=1`, `redirect_pc=0x120`; `flush_if`/`flush_id` high for 2 cycles, then IDLE.
- **BNE not taken.** `alu_zero=1`, type 010 → `redirect_valid=0`, no flush, `busy=0`.
- **JALR target alignment.** `alu_c=0x0000_2005`, type 110 → `redirect_pc=0x0000_2004`; an `ex_valid` branch presented during FLUSH is ignored.
- **Stall during FLUSH.** `stall=1` for 3 cycles mid-flush → flush held, counter frozen; total flush = 2 non-stalled cycles + 3 stalled cycles; `redirect_valid` is seen exactly once on a non-stalled edge.
- **BLT overflow.** rs1=0x8000_0000, rs2=1, so `alu_sgn=0`:
  - with `BR_OVF_FIX_EN`: `rs1_msb=1`, `rs2_msb=0` → taken.
  - without it: not taken.
- **Reset mid-FLUSH.** Assert `rst` asynchronously between edges → all outputs 0 immediately; after release the unit is in IDLE and resolves a JAL (`ex_pc=0x40`, `ex_imm=-8`) to `redirect_pc=0x38`.
